// File: rtl/mole_popup_ctrl.sv
// Whack-a-hole mole controller: picks a hole from an LFSR, lights it and judges the player's debounced press.
// Optional hit counter on the score output is built when SCORE_CNT_EN is defined.
module mole_popup_ctrl #(
    parameter int          TICK_DIV   = 5_000_000,
    parameter int          GAP_TICKS  = 5,
    parameter int          UP_TICKS   = 10,
    parameter int          SHOW_TICKS = 5,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] button_d,
    output logic [1:0] led,
    output logic       led_hit,
    output logic       led_miss,
    output logic       busy,
    output logic [7:0] score
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GAP    = 2'd1;
    localparam logic [1:0] UP     = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = (GAP_TICKS > UP_TICKS)
                          ? ((GAP_TICKS > SHOW_TICKS) ? GAP_TICKS : SHOW_TICKS)
                          : ((UP_TICKS > SHOW_TICKS) ? UP_TICKS : SHOW_TICKS);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    logic [PW-1:0] pre;
    logic          tick;
    logic [1:0]    btn_q;
    logic [1:0]    press;
    logic [7:0]    lfsr;
    logic [1:0]    state;
    logic [TW-1:0] tcnt;
    logic          hole;
    logic [1:0]    mole;
    logic          gap_done;
    logic          up_expired;
    logic          show_done;
    logic          up_hit;
    logic          up_miss;

    assign tick       = (pre == PW'(TICK_DIV - 1));
    assign press      = button_d & ~btn_q;
    assign mole       = hole ? 2'b10 : 2'b01;
    assign gap_done   = tick && (tcnt == TW'(GAP_TICKS - 1));
    assign up_expired = tick && (tcnt == TW'(UP_TICKS - 1));
    assign show_done  = tick && (tcnt == TW'(SHOW_TICKS - 1));
    // A press on the wrong hole (or both at once) always beats a hit or a timeout.
    assign up_miss    = (press == 2'b11) || ((press & ~mole) != 2'b00);
    assign up_hit     = (press == mole);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre   <= '0;
            btn_q <= 2'b00;
            lfsr  <= LFSR_SEED;
        end else begin
            pre   <= tick ? '0 : pre + PW'(1);
            btn_q <= button_d;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            tcnt     <= '0;
            hole     <= 1'b0;
            led      <= 2'b00;
            led_hit  <= 1'b0;
            led_miss <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (start) begin
                        state <= GAP;
                        busy  <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state <= UP;
                        tcnt  <= '0;
                        hole  <= lfsr[0];
                        led   <= lfsr[0] ? 2'b10 : 2'b01;
                    end else if (tick) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                UP: begin
                    if (up_miss || (!up_hit && up_expired)) begin
                        state    <= RESULT;
                        tcnt     <= '0;
                        led      <= 2'b00;
                        led_miss <= 1'b1;
                    end else if (up_hit) begin
                        state   <= RESULT;
                        tcnt    <= '0;
                        led     <= 2'b00;
                        led_hit <= 1'b1;
                    end else if (tick) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESULT: begin
                    if (show_done) begin
                        tcnt     <= '0;
                        led_hit  <= 1'b0;
                        led_miss <= 1'b0;
                        state    <= start ? GAP : IDLE;
                        busy     <= start;
                    end else if (tick) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCORE_CNT_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            score <= 8'd0;
        end else if (state == IDLE && start) begin
            score <= 8'd0;
        end else if (state == UP && up_hit && score != 8'hFF) begin
            score <= score + 8'd1;
        end
    end
`else
    assign score = 8'd0;
`endif

endmodule
